// File: rtl/wr_arb_pkg.sv
// wr_arb_pkg: shared types for the write port arbiter.
// Sequencer state encoding and its width; no ports.
package wr_arb_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE,
    ISSUE,
    WAIT_START,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, search from ptr+1.
// Ports: req (request vector), ptr (last winner),
//   win_oh / win_idx (winner), win_vld (any request).
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win_oh,
  output logic [IW-1:0] win_idx,
  output logic          win_vld
);

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_vld = |req;
    // farthest first, so the nearest one after ptr is left standing
    for (int k = N; k >= 1; k--) begin
      if (req[(int'(ptr) + k) % N]) begin
        win_idx = IW'((int'(ptr) + k) % N);
      end
    end
    if (win_vld) begin
      win_oh = N'(1) << win_idx;
    end
  end

endmodule

// File: rtl/write_port_arbiter.sv
// write_port_arbiter: round-robin sharing of one write-only device.
// Grants a requester, strobes dev_we, waits busy/ack, pulses done.
// Ports: clk, rst_n (async low); req/req_data from clients;
//   gnt/done/timeout one-hot pulses, owner, arb_busy;
//   dev_we/dev_data to device, dev_busy/dev_ack from device.
// Optional watchdog: define WR_ARB_TIMEOUT_EN.
module write_port_arbiter
  import wr_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [NUM_REQ-1:0]            timeout,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          arb_busy,
  output logic                          dev_we,
  output logic [DATA_WIDTH-1:0]         dev_data,
  input  logic                          dev_busy,
  input  logic                          dev_ack
);

  localparam int IW = $clog2(NUM_REQ);

  state_t             state;
  logic [IW-1:0]      ptr;
  logic [NUM_REQ-1:0] pick_oh;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req     (req),
    .ptr     (ptr),
    .win_oh  (pick_oh),
    .win_idx (pick_idx),
    .win_vld (pick_vld)
  );

`ifdef WR_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0]      to_cnt;
  logic [NUM_REQ-1:0] to_q;
  logic               to_hit;

  assign to_hit  = (to_cnt >= TW'(TIMEOUT_CYCLES - 1));
  assign timeout = to_q;

  // cleared while in ISSUE, so it starts at 0 in WAIT_START
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt <= '0;
    end else if (state == ISSUE) begin
      to_cnt <= '0;
    end else if (state == WAIT_START ||
                 state == WAIT_DONE) begin
      to_cnt <= to_cnt + TW'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign timeout    = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= IW'(NUM_REQ - 1);
      gnt      <= '0;
      done     <= '0;
      owner    <= '0;
      arb_busy <= 1'b0;
      dev_we   <= 1'b0;
      dev_data <= '0;
`ifdef WR_ARB_TIMEOUT_EN
      to_q     <= '0;
`endif
    end else begin
      gnt    <= '0;
      done   <= '0;
      dev_we <= 1'b0;
`ifdef WR_ARB_TIMEOUT_EN
      to_q   <= '0;
`endif
      unique case (state)
        IDLE: begin
          if (pick_vld && !dev_busy) begin
            gnt      <= pick_oh;
            dev_data <= req_data[int'(pick_idx)*DATA_WIDTH +: DATA_WIDTH];
            owner    <= pick_idx;
            ptr      <= pick_idx;
            dev_we   <= 1'b1;
            arb_busy <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          state <= WAIT_START;
        end
        WAIT_START: begin
          if (dev_busy) begin
            state <= WAIT_DONE;
          end
`ifdef WR_ARB_TIMEOUT_EN
          else if (to_hit) begin
            to_q     <= NUM_REQ'(1) << owner;
            arb_busy <= 1'b0;
            state    <= IDLE;
          end
`endif
        end
        WAIT_DONE: begin
          // busy low without ack is not a completion
          if (!dev_busy && dev_ack) begin
            done     <= NUM_REQ'(1) << owner;
            arb_busy <= 1'b0;
            state    <= IDLE;
          end
`ifdef WR_ARB_TIMEOUT_EN
          else if (to_hit) begin
            to_q     <= NUM_REQ'(1) << owner;
            arb_busy <= 1'b0;
            state    <= IDLE;
          end
`endif
        end
        default: begin
          arb_busy <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_write_port_arbiter.sv
// tb_write_port_arbiter: randomized bench with a transaction model.
// Drives a device model and checks every output each cycle.
module tb_write_port_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [N-1:0]   timeout;
  logic [1:0]     owner;
  logic           arb_busy;
  logic           dev_we;
  logic [W-1:0]   dev_data;
  logic           dev_busy;
  logic           dev_ack;

  write_port_arbiter #(
    .DATA_WIDTH     (W),
    .NUM_REQ        (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .timeout  (timeout),
    .owner    (owner),
    .arb_busy (arb_busy),
    .dev_we   (dev_we),
    .dev_data (dev_data),
    .dev_busy (dev_busy),
    .dev_ack  (dev_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // transaction-level model
  bit       m_free = 1'b1;
  int       m_ptr  = N - 1;
  int       m_owner;
  logic [W-1:0] m_data;
  int       m_done_at;
  int       m_lat;
  bit       m_to;
  bit       m_mute;
  int       lat_cfg;
  int       edge_no;
  int       g_edge;
  logic [N-1:0] e_gnt;
  logic [N-1:0] e_done;
  logic [N-1:0] e_to;
  logic         e_we;

  // device model and observation
  int       dev_cnt;
  int       ext_cnt;
  logic [W-1:0] obs_data[$];
  int       g3_cnt;
  int       to_edge;
  logic [N-1:0] done_acc;

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // next requester after p, by rotating the request vector
  function automatic int rr_next(logic [N-1:0] r, int p);
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    dbl = {r, r};
    rot = N'(dbl >> (p + 1));
    for (int k = 0; k < N; k++) begin
      if (rot[k]) return (p + 1 + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    int w;
    e_gnt  = '0;
    e_done = '0;
    e_to   = '0;
    e_we   = 1'b0;
    if (!m_free && edge_no == m_done_at) begin
      if (m_to) e_to = N'(1) << m_owner;
      else      e_done = N'(1) << m_owner;
      m_free = 1'b1;
    end else if (m_free && (|req) && !dev_busy) begin
      w        = rr_next(req, m_ptr);
      e_gnt    = N'(1) << w;
      e_we     = 1'b1;
      m_owner  = w;
      m_ptr    = w;
      m_data   = req_data[w*W +: W];
      m_lat    = (lat_cfg != 0) ? lat_cfg
                                : int'($urandom_range(2, 6));
      m_to     = m_mute;
      m_done_at = m_mute ? edge_no + 1 + TO
                         : edge_no + m_lat + 1;
      g_edge   = edge_no;
      m_free   = 1'b0;
    end
    @(posedge clk);
    edge_no++;
    @(negedge clk);
    check("gnt", 32'(gnt), 32'(e_gnt));
    check("dev_we", 32'(dev_we), 32'(e_we));
    check("done", 32'(done), 32'(e_done));
    check("timeout", 32'(timeout), 32'(e_to));
    check("arb_busy", 32'(arb_busy), 32'(!m_free));
    check("owner", 32'(owner), 32'(m_owner));
    check("dev_data", 32'(dev_data), 32'(m_data));
    if (dev_we) obs_data.push_back(dev_data);
    if (gnt[3]) g3_cnt++;
    if (|timeout) to_edge = edge_no - 1;
    done_acc |= done;
    if (dev_we === 1'b1 && !m_mute) begin
      dev_busy = 1'b1;
      dev_ack  = 1'b0;
      dev_cnt  = m_lat;
    end else if (dev_cnt > 0) begin
      dev_cnt--;
      if (dev_cnt == 0) begin
        dev_busy = 1'b0;
        dev_ack  = 1'b1;
      end
    end
  endtask

  task automatic rand_inputs();
    for (int i = 0; i < N; i++) begin
      if (e_gnt[i]) begin
        req[i] = 1'($urandom_range(0, 1));
      end else if (req[i]) begin
        if ($urandom_range(0, 15) == 0) req[i] = 1'b0;
      end else if ($urandom_range(0, 2) == 0) begin
        req[i] = 1'b1;
      end
      req_data[i*W +: W] = W'($urandom);
    end
    if (m_free && dev_cnt == 0) begin
      if (ext_cnt > 0) begin
        ext_cnt--;
        dev_busy = (ext_cnt > 0);
      end else if ($urandom_range(0, 9) == 0) begin
        ext_cnt  = $urandom_range(1, 4);
        dev_busy = 1'b1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n   = 0;
    req = '0;
    while (!m_free && n < 200) begin
      step();
      n++;
    end
    check("drain_bound", 32'(m_free), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_dev_we", 32'(dev_we), 32'd0);
    check("rst_dev_data", 32'(dev_data), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_arb_busy", 32'(arb_busy), 32'd0);
    m_free   = 1'b1;
    m_ptr    = N - 1;
    m_owner  = 0;
    m_data   = '0;
    m_to     = 1'b0;
    dev_busy = 1'b0;
    dev_ack  = 1'b0;
    dev_cnt  = 0;
    ext_cnt  = 0;
    req      = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    dev_busy = 1'b0;
    dev_ack  = 1'b0;
    lat_cfg  = 0;
    m_mute   = 1'b0;
    to_edge  = -1;
    @(negedge clk);
    do_reset();

    // single request
    done_acc = '0;
    req      = 4'b0010;
    req_data = {8'h01, 8'h02, 8'hAA, 8'h03};
    step();
    check("single_gnt", 32'(gnt), 32'h2);
    check("single_data", 32'(dev_data), 32'hAA);
    drain();
    check("single_done", 32'(done_acc), 32'h2);

    // all four held high
    do_reset();
    obs_data.delete();
    req      = 4'b1111;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};
    n = 0;
    while (obs_data.size() < 5 && n < 200) begin
      step();
      n++;
    end
    drain();
    check("seq_len", 32'(obs_data.size()), 32'd5);
    if (obs_data.size() >= 5) begin
      check("seq0", 32'(obs_data[0]), 32'h11);
      check("seq1", 32'(obs_data[1]), 32'h22);
      check("seq2", 32'(obs_data[2]), 32'h33);
      check("seq3", 32'(obs_data[3]), 32'h44);
      check("seq4", 32'(obs_data[4]), 32'h11);
    end

    // device busy while idle
    obs_data.delete();
    dev_busy = 1'b1;
    req      = 4'b0001;
    for (int i = 0; i < 5; i++) step();
    check("busy_idle_we", 32'(obs_data.size()), 32'd0);
    dev_busy = 1'b0;
    step();
    check("busy_rel_gnt", 32'(gnt), 32'h1);
    drain();

    // reset in WAIT_DONE
    lat_cfg  = 6;
    req      = 4'b0100;
    req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
    step();
    req = '0;
    for (int i = 0; i < 3; i++) step();
    check("mid_busy", 32'(arb_busy), 32'd1);
    do_reset();
    req = 4'b1111;
    step();
    check("post_rst_gnt", 32'(gnt), 32'h1);
    drain();

    // requester 3 drops just before its turn
    do_reset();
    lat_cfg = 4;
    g3_cnt  = 0;
    req     = 4'b0011;
    step();
    req = 4'b1010;
    while (edge_no < m_done_at) step();
    step();
    step();
    check("drop_gnt1", 32'(gnt), 32'h2);
    req = 4'b1001;
    while (edge_no < m_done_at) step();
    req[3] = 1'b0;
    step();
    step();
    check("drop_gnt0", 32'(gnt), 32'h1);
    drain();
    check("drop_no_g3", 32'(g3_cnt), 32'd0);
    lat_cfg = 0;

`ifdef WR_ARB_TIMEOUT_EN
    // silent device triggers the watchdog
    m_mute  = 1'b1;
    to_edge = -1;
    req     = 4'b0100;
    step();
    drain();
    check("to_delay", 32'(to_edge - (g_edge + 1)), 32'(TO));
    m_mute = 1'b0;
    req    = 4'b1111;
    step();
    check("to_ptr_kept", 32'(gnt), 32'h8);
    drain();
`endif

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rand_inputs();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
